// File: rtl/z_result_drain_if.sv
// Handshake bundle between the ALU result source, the Z drain and the internal bus.
// The slave modport is the drain's view; the master modport is the ALU/bus side.
interface z_result_drain_if #(
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic              alu_ready;
    logic [DATA_W-1:0] alu_lo;
    logic [DATA_W-1:0] alu_hi;
    logic              alu_wide;
    logic              bus_valid;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_data;
    logic              bus_sel_hi;

    modport slave (
        input  alu_valid, alu_lo, alu_hi, alu_wide, bus_ready,
        output alu_ready, bus_valid, bus_data, bus_sel_hi
    );

    modport master (
        output alu_valid, alu_lo, alu_hi, alu_wide, bus_ready,
        input  alu_ready, bus_valid, bus_data, bus_sel_hi
    );
endinterface

// File: rtl/z_result_drain.sv
// Captures the ALU Z result into ZLO/ZHI and drains it onto the internal bus in one or two beats.
// Optional macro Z_FLAGS_EN builds the zero/negative flag registers captured with each result.
module z_result_drain #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clock,
    input  logic               clear_n,
    z_result_drain_if.slave    io,
    output logic [DATA_W-1:0]  zlo_q,
    output logic [DATA_W-1:0]  zhi_q,
    output logic [CNT_W-1:0]   xfer_count,
    output logic               zero_flag,
    output logic               neg_flag
);
    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_zlo;
    logic [DATA_W-1:0]   r_zhi;
    logic                r_wide;
    logic [CNT_W-1:0]    r_xfer_count;
    logic                r_bus_valid;
    logic [DATA_W-1:0]   r_bus_data;
    logic                r_bus_sel_hi;
    logic                w_alu_ready;
    logic                w_capture;
    logic                w_complete;

    // Ready opens in the cycle the current result finishes, so narrow results stream without bubbles.
    always_comb begin
        w_alu_ready = 1'b0;
        case (r_state)
            IDLE:    w_alu_ready = 1'b1;
            SEND_LO: w_alu_ready = io.bus_ready & ~r_wide;
            SEND_HI: w_alu_ready = io.bus_ready;
            default: w_alu_ready = 1'b0;
        endcase
    end

    assign w_capture  = io.alu_valid & w_alu_ready;
    assign w_complete = io.bus_ready &
                        (((r_state == SEND_LO) & ~r_wide) | (r_state == SEND_HI));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state      <= IDLE;
            r_zlo        <= '0;
            r_zhi        <= '0;
            r_wide       <= 1'b0;
            r_xfer_count <= '0;
            r_bus_valid  <= 1'b0;
            r_bus_data   <= '0;
            r_bus_sel_hi <= 1'b0;
        end else begin
            if (w_complete) begin
                r_xfer_count <= r_xfer_count + CNT_W'(1);
            end
            if (w_capture) begin
                r_zlo        <= io.alu_lo;
                r_zhi        <= io.alu_wide ? io.alu_hi : '0;
                r_wide       <= io.alu_wide;
                r_state      <= SEND_LO;
                r_bus_valid  <= 1'b1;
                r_bus_data   <= io.alu_lo;
                r_bus_sel_hi <= 1'b0;
            end else begin
                case (r_state)
                    SEND_LO: begin
                        if (io.bus_ready) begin
                            if (r_wide) begin
                                r_state      <= SEND_HI;
                                r_bus_data   <= r_zhi;
                                r_bus_sel_hi <= 1'b1;
                            end else begin
                                r_state      <= IDLE;
                                r_bus_valid  <= 1'b0;
                                r_bus_data   <= '0;
                                r_bus_sel_hi <= 1'b0;
                            end
                        end
                    end
                    SEND_HI: begin
                        if (io.bus_ready) begin
                            r_state      <= IDLE;
                            r_bus_valid  <= 1'b0;
                            r_bus_data   <= '0;
                            r_bus_sel_hi <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef Z_FLAGS_EN
    logic r_zero_flag;
    logic r_neg_flag;

    // Flags describe the whole result: both words for wide ops, the low word otherwise.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_zero_flag <= 1'b0;
            r_neg_flag  <= 1'b0;
        end else if (w_capture) begin
            r_zero_flag <= io.alu_wide ? ((io.alu_hi | io.alu_lo) == '0) : (io.alu_lo == '0);
            r_neg_flag  <= io.alu_wide ? io.alu_hi[DATA_W-1] : io.alu_lo[DATA_W-1];
        end
    end

    assign zero_flag = r_zero_flag;
    assign neg_flag  = r_neg_flag;
`else
    assign zero_flag = 1'b0;
    assign neg_flag  = 1'b0;
`endif

    assign io.alu_ready  = w_alu_ready;
    assign io.bus_valid  = r_bus_valid;
    assign io.bus_data   = r_bus_data;
    assign io.bus_sel_hi = r_bus_sel_hi;
    assign zlo_q         = r_zlo;
    assign zhi_q         = r_zhi;
    assign xfer_count    = r_xfer_count;
endmodule

// File: doc/z_result_drain.md
Name: z_result_drain

Overview:
- Consumer end of the ALU result path: the ALU units (and_op, or_op, add, mul, div) drive a combinational Z result; this block captures it into the ZLO/ZHI holding registers via a valid/ready handshake.
- It then drains the captured result onto the 32-bit internal bus, one beat for narrow results and two beats (ZLO then ZHI) for wide mul/div results.
- It sits between the ALU output and the bus multiplexer.
- It replaces free-running Z latching with a flow-controlled writeback.

Parameters:
- DATA_W, 32, width of one bus beat and of each of ZLO/ZHI.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clock  in  1  rising-edge clock.
- clear_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  block accepts the result this cycle.
- alu_lo  in  DATA_W  low word of the result (the full result for narrow ops).
- alu_hi  in  DATA_W  high word; ignored when alu_wide=0.
- alu_wide  in  1  1 = 64-bit result (mul/div), 0 = 32-bit result.
- bus_valid  out  1  beat available on bus_data.
- bus_ready  in  1  bus consumes the beat this cycle.
- bus_data  out  DATA_W  current beat.
- bus_sel_hi  out  1  1 when the beat is ZHI, 0 when it is ZLO.
- zlo_q  out  DATA_W  ZLO holding register.
- zhi_q  out  DATA_W  ZHI holding register.
- xfer_count  out  CNT_W  number of completed results.
- zero_flag  out  1  see Optional Feature.
- neg_flag  out  1  see Optional Feature.

Behaviour:
- Reset (clear_n=0, async), all outputs to known values:
  - state=IDLE.
  - zlo_q=0, zhi_q=0, xfer_count=0.
  - bus_valid=0, bus_data=0, bus_sel_hi=0.
  - zero_flag=0, neg_flag=0.
  - alu_ready=1 after release.
- Accept: a capture occurs on a rising edge with alu_valid & alu_ready.
  - zlo_q <= alu_lo.
  - zhi_q <= alu_wide ? alu_hi : 0.
  - wide_q <= alu_wide.
  - Next state is SEND_LO.
- States:
  - IDLE: bus_valid=0; alu_ready=1.
  - SEND_LO: bus_valid=1, bus_data=zlo_q, bus_sel_hi=0.
    - On bus_ready with wide_q=1: go to SEND_HI.
    - On bus_ready with wide_q=0: the result completes.
  - SEND_HI: bus_valid=1, bus_data=zhi_q, bus_sel_hi=1.
    - On bus_ready: the result completes.
- Completion: xfer_count increments by 1, wrapping from all-ones to 0.
  - Next state is SEND_LO if a new capture occurs in the same cycle, else IDLE.
- alu_ready is combinational:
  - 1 in IDLE.
  - bus_ready & ~wide_q in SEND_LO.
  - bus_ready in SEND_HI.
  - 0 otherwise.
  - Result: back-to-back narrow results sustain one beat per cycle with no bubble.
- Stall: while bus_valid=1 and bus_ready=0, bus_data, bus_sel_hi, zlo_q, zhi_q and state hold; alu_valid is ignored.
- Latency: bus_valid asserts the cycle after capture. A narrow result completes in 1 cycle with bus_ready held high; a wide result completes in 2.
- bus_data and bus_sel_hi are decoded from state and registers; bus_data is 0 in IDLE.
- Simultaneous completion and capture: completion counts and new data loads in the same edge; no data is lost or duplicated.
- Reset mid-transfer: the in-flight result is discarded, with no partial count.
- alu_hi is never driven onto the bus for narrow results, since ZHI reads 0.

Optional Feature:
- Macro: Z_FLAGS_EN.
- Defined: zero_flag and neg_flag are registered at capture.
  - zero_flag = (alu_wide ? (alu_hi|alu_lo) : alu_lo) == 0.
  - neg_flag = alu_wide ? alu_hi[DATA_W-1] : alu_lo[DATA_W-1].
  - Both flags hold until the next capture and reset to 0.
- Undefined: zero_flag and neg_flag are tied to 0 and no flag registers are built; the port list is unchanged.

Test Plan:
- Reset then narrow result: alu_lo=0xFFFF0000, alu_wide=0, bus_ready=1 -> next cycle bus_valid=1, bus_data=0xFFFF0000, bus_sel_hi=0, zhi_q=0; following cycle xfer_count=1, IDLE.
- Wide result: alu_hi=0x00000001, alu_lo=0x80000000, alu_wide=1, bus_ready=1 -> beat 0x80000000 (sel_hi=0), then beat 0x00000001 (sel_hi=1); alu_ready=0 during the LO beat; xfer_count=1.
- Back-to-back: alu_valid held with narrow values 0xA, 0xB, 0xC and bus_ready=1 -> beats 0xA, 0xB, 0xC on consecutive cycles; xfer_count=3.
- Backpressure: bus_ready=0 for 5 cycles during SEND_HI -> bus_data and sel_hi stable and alu_ready=0 throughout; completes 1 cycle after bus_ready=1.
- Async reset: clear_n pulsed low mid-SEND_HI, asynchronous to clock -> bus_valid=0 immediately, xfer_count=0, IDLE, alu_ready=1 after release.
- Z_FLAGS_EN: wide result 0/0 -> zero_flag=1, neg_flag=0; narrow 0x80000000 -> zero_flag=0, neg_flag=1. Without the macro, both flags stay 0.
